mc_ctrl_fsm: RTL

Parametrised multicycle MIPS control unit: main-decoder FSM plus ALU decoder in one block, driving the shared-memory multicycle datapath. Extends the base controller with bne, andi/ori/slti, and configurable memory wait states. It also adds a visible state output and an optional illegal-instruction trap. Sits between the instruction register (op/funct) and the datapath muxes, register file and memory enables.

---
 rtl/mc_ctrl_if.sv | 51 +++++
 rtl/mc_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_if
// Description : Bundle between the multicycle MIPS controller and its
//               datapath. The instruction-register fields and the ALU zero
//               flag come in. The mux selects, write enables, ALU operation
//               and debug/trap status go out.
//   master : controller side (drives the control outputs)
//   slave  : datapath side (drives op/funct/zero)
// Parameter   : ALUCTRL_W - alucontrol width. Must match the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_ctrl_if #(
    parameter int ALUCTRL_W = 3
);
    // Inputs to the controller
    logic [5:0]           op;
    logic [5:0]           funct;
    logic                 zero;

    // Outputs from the controller
    logic                 memtoreg;
    logic                 memwrite;
    logic                 iord;
    logic                 irwrite;
    logic                 regdst;
    logic                 regwrite;
    logic                 alusrca;
    logic [1:0]           alusrcb;
    logic                 immzext;
    logic [1:0]           pcsrc;
    logic                 pcen;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic [3:0]           state;
    logic                 illegal;

    modport master (
        input  op, funct, zero,
        output memtoreg, memwrite, iord, irwrite, regdst, regwrite,
               alusrca, alusrcb, immzext, pcsrc, pcen, alucontrol,
               state, illegal
    );

    modport slave (
        output op, funct, zero,
        input  memtoreg, memwrite, iord, irwrite, regdst, regwrite,
               alusrca, alusrcb, immzext, pcsrc, pcen, alucontrol,
               state, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multicycle MIPS control unit. It contains the main-decoder
//               FSM and the ALU decoder. Supported instructions are lw, sw,
//               R-type, beq, bne, addi, andi, ori, slti and j. Each memory
//               access can take a configurable number of wait cycles.
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-low reset
//               bus   - mc_ctrl_if.master. Carries op/funct/zero in and all
//                       datapath controls plus state/illegal out.
// Parameters  : MEM_LAT   - extra wait cycles per memory access (0..15)
//               ALUCTRL_W - alucontrol width (3-bit codes are zero-extended)
// Options     : CTRL_ILLEGAL_EN - when defined, an undefined opcode or an
//               undefined R-type funct traps to TRAP and raises illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int MEM_LAT   = 0,
    parameter int ALUCTRL_W = 3
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mc_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    // $clog2(1) is 0, so MEM_LAT=0 still gets a 1-bit counter
    localparam int             c_CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT = c_CNT_W'(MEM_LAT);

    state_t               r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;

    logic       w_is_mem;
    logic       w_mem_done;
    logic       w_isbne;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;
    logic [2:0] w_alu3;

    logic       w_memtoreg, w_memwrite, w_iord, w_irwrite, w_regdst;
    logic       w_regwrite, w_alusrca, w_immzext;
    logic [1:0] w_alusrcb, w_pcsrc;

    // ------------------------------------------------------------------
    // State and wait-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q <= S_FETCH;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // A memory state finishes on the cycle where the counter reaches MEM_LAT.
    // The counter returns to 0 on that cycle, so the next state starts clean.
    assign w_is_mem   = (r_state_q == S_FETCH) || (r_state_q == S_MEMRD) ||
                        (r_state_q == S_MEMWR);
    assign w_mem_done = w_is_mem && (r_cnt_q == c_LAT);
    assign w_cnt_d    = (w_is_mem && !w_mem_done) ? (r_cnt_q + c_CNT_W'(1)) : '0;

`ifdef CTRL_ILLEGAL_EN
    logic w_funct_known;
    always_comb begin
        w_funct_known = 1'b0;
        case (bus.funct)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010: w_funct_known = 1'b1;
            default:              w_funct_known = 1'b0;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_FETCH:  w_state_d = w_mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    c_OP_LW, c_OP_SW:      w_state_d = S_MEMADR;
`ifdef CTRL_ILLEGAL_EN
                    c_OP_RTYPE:            w_state_d = w_funct_known ? S_REX : S_TRAP;
`else
                    c_OP_RTYPE:            w_state_d = S_REX;
`endif
                    c_OP_BEQ, c_OP_BNE:    w_state_d = S_BRANCH;
                    c_OP_ADDI, c_OP_ANDI,
                    c_OP_ORI, c_OP_SLTI:   w_state_d = S_IMMEX;
                    c_OP_J:                w_state_d = S_JUMP;
`ifdef CTRL_ILLEGAL_EN
                    default:               w_state_d = S_TRAP;
`else
                    default:               w_state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: w_state_d = (bus.op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_state_d = w_mem_done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_state_d = w_mem_done ? S_FETCH : S_MEMWR;
            S_REX:    w_state_d = S_ALUWB;
            S_IMMEX:  w_state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB,
            S_BRANCH, S_JUMP:  w_state_d = S_FETCH;
            S_TRAP:   w_state_d = S_TRAP;       // only reset leaves TRAP
            default:  w_state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-state control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_memtoreg = 1'b0;
        w_memwrite = 1'b0;
        w_iord     = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_immzext  = 1'b0;
        w_pcsrc    = 2'b00;
        w_aluop    = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        case (r_state_q)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                // IR load and PC+4 happen once, when the read data is valid
                w_irwrite = w_mem_done;
                w_pcwrite = w_mem_done;
            end
            S_DECODE: w_alusrcb = 2'b11;
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD:  w_iord = 1'b1;
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = w_mem_done;
            end
            S_REX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            S_IMMEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_aluop   = 2'b11;
                w_immzext = (bus.op == c_OP_ANDI) || (bus.op == c_OP_ORI);
            end
            S_IMMWB:  w_regwrite = 1'b1;
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;                          // TRAP: everything idle
        endcase
    end

    // beq takes the branch on zero, bne on not-zero
    assign w_isbne = (bus.op == c_OP_BNE);

    // ------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------
    always_comb begin
        w_alu3 = 3'b010;
        case (w_aluop)
            2'b00: w_alu3 = 3'b010;
            2'b01: w_alu3 = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: w_alu3 = 3'b010;
                    6'b100010: w_alu3 = 3'b110;
                    6'b100100: w_alu3 = 3'b000;
                    6'b100101: w_alu3 = 3'b001;
                    6'b101010: w_alu3 = 3'b111;
                    default:   w_alu3 = 3'b010;
                endcase
            end
            default: begin
                case (bus.op)
                    c_OP_ANDI: w_alu3 = 3'b000;
                    c_OP_ORI:  w_alu3 = 3'b001;
                    c_OP_SLTI: w_alu3 = 3'b111;
                    default:   w_alu3 = 3'b010;
                endcase
            end
        endcase
    end

    assign bus.memtoreg   = w_memtoreg;
    assign bus.memwrite   = w_memwrite;
    assign bus.iord       = w_iord;
    assign bus.irwrite    = w_irwrite;
    assign bus.regdst     = w_regdst;
    assign bus.regwrite   = w_regwrite;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.immzext    = w_immzext;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.pcen       = w_pcwrite | (w_branch & (bus.zero ^ w_isbne));
    assign bus.alucontrol = ALUCTRL_W'(w_alu3);
    assign bus.state      = r_state_q;

`ifdef CTRL_ILLEGAL_EN
    assign bus.illegal = (r_state_q == S_TRAP);
`else
    assign bus.illegal = 1'b0;
`endif

endmodule
`default_nettype wire
